// File: rtl/flipflop_in_pkg.sv
// Shared constants for the input-side plugins: edge selection codes and synchroniser depth.
// The edge-qualification helper is used by every plugin that turns an accepted level change into an event.
package flipflop_in_pkg;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;

    localparam int SYNC_STAGES  = 2;

    // new_level is the level being accepted at this edge
    function automatic logic edge_qualifies(input int edge_sel, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (edge_sel)
            EDGE_RISING:  hit = new_level;
            EDGE_FALLING: hit = ~new_level;
            EDGE_BOTH:    hit = 1'b1;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/bit_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// accept is high in the cycle where the pending level is taken into out.
module bit_debounce
    import flipflop_in_pkg::*;
#(
    parameter logic DEFAULT  = 1'b0,
    parameter int   DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic accept
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   out_reg, out_next;
    logic                   s2;
    logic                   differ;

    assign s2 = sync_reg[SYNC_STAGES-1];

    // Sync stages preload the reset level so no spurious change is seen after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= {SYNC_STAGES{DEFAULT}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
        end
    end

    always_comb begin
        differ   = (s2 != out_reg);
        accept   = differ && (cnt_reg == CNT_MAX);
        cnt_next = '0;
        out_next = out_reg;
        if (accept) begin
            out_next = s2;
        end else if (differ) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            out_reg <= DEFAULT;
        end else begin
            cnt_reg <= cnt_next;
            out_reg <= out_next;
        end
    end

    assign out = out_reg;

endmodule

// File: rtl/flipflop_in.sv
// Debounced input pin with sticky edge flag (host-cleared) and a wrapping event counter.
// The flag and counter update on the same edge that the debouncer accepts the new level.
module flipflop_in
    import flipflop_in_pkg::*;
#(
    parameter logic DEFAULT   = 1'b0,
    parameter int   DEBOUNCE  = 16,
    parameter int   EDGE      = EDGE_RISING,
    parameter logic INVERT    = 1'b0,
    parameter int   CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pin,
    input  logic                 clear,
    output logic                 value,
    output logic                 latched,
    output logic [CNT_WIDTH-1:0] events
);

    logic                 pin_s;
    logic                 accept;
    logic                 q;
    logic                 latched_reg, latched_next;
    logic [CNT_WIDTH-1:0] events_reg, events_next;

    assign pin_s = pin ^ INVERT;

    bit_debounce #(
        .DEFAULT  (DEFAULT),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .in     (pin_s),
        .out    (value),
        .accept (accept)
    );

    // On accept the new level is the complement of the current one
    always_comb begin
        q            = accept && edge_qualifies(EDGE, ~value);
        latched_next = latched_reg;
        events_next  = events_reg;
        if (q) begin
            latched_next = 1'b1;
            events_next  = events_reg + 1'b1;
        end else if (clear) begin
            latched_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latched_reg <= 1'b0;
            events_reg  <= '0;
        end else begin
            latched_reg <= latched_next;
            events_reg  <= events_next;
        end
    end

    assign latched = latched_reg;
    assign events  = events_reg;

endmodule
